// File: rtl/multi_mode_counter.sv
// Prescaled multi-mode counter: hold / up / down / odd-step on each prescaler tick,
// with synchronous load, registered tick and wrap pulses, and async active-low clear.
module multi_mode_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 50_000_000
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             wrap
);

  // A 1-bit prescaler still exists for DIV=1; it simply never leaves 0.
  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0]  PreMax = PreW'(DIV - 1);
  localparam logic [PreW-1:0]  PreOne = PreW'(1);
  localparam logic [WIDTH-1:0] QMax   = '1;
  localparam logic [WIDTH-1:0] QOne   = WIDTH'(1);
  localparam logic [WIDTH-1:0] QTwo   = WIDTH'(2);

  typedef enum logic [1:0] {
    ModeHold = 2'b00,
    ModeUp   = 2'b01,
    ModeDown = 2'b10,
    ModeOdd  = 2'b11
  } mode_e;

  logic [PreW-1:0]  pre_q, pre_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic             tick_cycle;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  mode_e            mode;

  assign mode       = mode_e'(sel);
  assign tick_cycle = en && (pre_q == PreMax);

  // Candidate count step for the current mode; only committed on a tick cycle.
  always_comb begin
    step_val  = q_q;
    step_wrap = 1'b0;
    unique case (mode)
      ModeHold: begin
        step_val  = q_q;
        step_wrap = 1'b0;
      end
      ModeUp: begin
        step_val  = q_q + QOne;
        step_wrap = (q_q == QMax);
      end
      ModeDown: begin
        step_val  = q_q - QOne;
        step_wrap = (q_q == '0);
      end
      ModeOdd: begin
        if (!q_q[0]) begin
          step_val = q_q + QOne;
        end else if (q_q == QMax) begin
          step_val  = QOne;
          step_wrap = 1'b1;
        end else begin
          step_val = q_q + QTwo;
        end
      end
      default: begin
        step_val  = q_q;
        step_wrap = 1'b0;
      end
    endcase
  end

  // Load has priority over any tick-driven step and restarts the prescaler.
  always_comb begin
    pre_d  = pre_q;
    q_d    = q_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (load) begin
      pre_d = '0;
      q_d   = D;
    end else begin
      if (en) begin
        pre_d = tick_cycle ? '0 : pre_q + PreOne;
      end
      if (tick_cycle) begin
        q_d    = step_val;
        tick_d = 1'b1;
        wrap_d = step_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      pre_q  <= '0;
      q_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      q_q    <= q_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed bench for multi_mode_counter with WIDTH=4, DIV=4.
module tb_multi_mode_counter;

  logic       clk   = 1'b0;
  logic       Clear = 1'b0;
  logic       en    = 1'b0;
  logic [1:0] sel   = 2'b00;
  logic       load  = 1'b0;
  logic [3:0] D     = 4'd0;
  logic [3:0] Q;
  logic       tick;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  multi_mode_counter #(
    .WIDTH(4),
    .DIV  (4)
  ) dut (
    .clk  (clk),
    .Clear(Clear),
    .en   (en),
    .sel  (sel),
    .load (load),
    .D    (D),
    .Q    (Q),
    .tick (tick),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    D    = v;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    Clear = 1'b0;
    en    = 1'b0;
    advance(2);
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", Q); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
    Clear = 1'b1;
    sel   = 2'b00;
    do_load(4'd9);
    en = 1'b1;
    advance(2);
    checks++; if (Q !== 4'd9) begin errors++; $display("FAIL preclear_q: got %0d expected 9", Q); end
    // Assert clear between edges: outputs must drop without a clock.
    Clear = 1'b0;
    #1;
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL midclear_q: got %0d expected 0", Q); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midclear_tick: got %b expected 0", tick); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL midclear_wrap: got %b expected 0", wrap); end
    #1;
    Clear = 1'b1;
    sel   = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL postclear_early_tick%0d: got %b expected 0", i, tick); end
    end
    step();
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL postclear_tick: got %b expected 1", tick); end
    checks++; if (Q !== 4'd1) begin errors++; $display("FAIL postclear_q: got %0d expected 1", Q); end
    step();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL postclear_tick_pulse: got %b expected 0", tick); end
  endtask

  task automatic test_up_wrap();
    en  = 1'b1;
    sel = 2'b01;
    do_load(4'd14);
    checks++; if (Q !== 4'd14) begin errors++; $display("FAIL up_load_q: got %0d expected 14", Q); end
    checks++; if (tick !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL up_load_flags: got tick %b wrap %b expected 0 0", tick, wrap); end
    advance(3);
    step();
    checks++; if (Q !== 4'd15 || tick !== 1'b1 || wrap !== 1'b0) begin errors++; $display("FAIL up_15: got q %0d tick %b wrap %b expected 15 1 0", Q, tick, wrap); end
    advance(3);
    step();
    checks++; if (Q !== 4'd0 || tick !== 1'b1 || wrap !== 1'b1) begin errors++; $display("FAIL up_wrap: got q %0d tick %b wrap %b expected 0 1 1", Q, tick, wrap); end
    step();
    checks++; if (wrap !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL up_wrap_pulse: got tick %b wrap %b expected 0 0", tick, wrap); end
  endtask

  task automatic test_down_wrap();
    en  = 1'b1;
    sel = 2'b10;
    do_load(4'd1);
    advance(3);
    step();
    checks++; if (Q !== 4'd0 || wrap !== 1'b0) begin errors++; $display("FAIL down_0: got q %0d wrap %b expected 0 0", Q, wrap); end
    advance(3);
    step();
    checks++; if (Q !== 4'd15 || wrap !== 1'b1) begin errors++; $display("FAIL down_wrap: got q %0d wrap %b expected 15 1", Q, wrap); end
    step();
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_wrap_pulse: got %b expected 0", wrap); end
  endtask

  task automatic test_odd_step();
    logic [3:0] exp_q [6];
    exp_q = '{4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd1};
    en  = 1'b1;
    sel = 2'b11;
    do_load(4'd6);
    for (int i = 0; i < 6; i++) begin
      advance(3);
      step();
      checks++;
      if (Q !== exp_q[i] || wrap !== (i == 5)) begin
        errors++;
        $display("FAIL odd_step%0d: got q %0d wrap %b expected %0d %b", i, Q, wrap, exp_q[i], (i == 5));
      end
    end
  endtask

  task automatic test_collision();
    en  = 1'b1;
    sel = 2'b01;
    do_load(4'd5);
    advance(3);
    do_load(4'd3);
    checks++; if (Q !== 4'd3 || tick !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL collide: got q %0d tick %b wrap %b expected 3 0 0", Q, tick, wrap); end
    advance(3);
    checks++; if (tick !== 1'b0 || Q !== 4'd3) begin errors++; $display("FAIL collide_prescaler: got q %0d tick %b expected 3 0", Q, tick); end
    step();
    checks++; if (tick !== 1'b1 || Q !== 4'd4) begin errors++; $display("FAIL collide_next: got q %0d tick %b expected 4 1", Q, tick); end
    // A load on what would be a wrapping tick must also suppress wrap.
    do_load(4'd15);
    advance(3);
    do_load(4'd3);
    checks++; if (Q !== 4'd3 || tick !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL collide_wrap: got q %0d tick %b wrap %b expected 3 0 0", Q, tick, wrap); end
  endtask

  task automatic test_freeze_hold();
    en  = 1'b1;
    sel = 2'b01;
    do_load(4'd2);
    advance(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (Q !== 4'd2 || tick !== 1'b0) begin errors++; $display("FAIL freeze%0d: got q %0d tick %b expected 2 0", i, Q, tick); end
    end
    en  = 1'b1;
    sel = 2'b00;
    step();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL freeze_resume: got tick %b expected 0", tick); end
    step();
    checks++; if (tick !== 1'b1 || Q !== 4'd2 || wrap !== 1'b0) begin errors++; $display("FAIL hold_tick0: got q %0d tick %b wrap %b expected 2 1 0", Q, tick, wrap); end
    for (int k = 1; k < 3; k++) begin
      advance(3);
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL hold_gap%0d: got tick %b expected 0", k, tick); end
      step();
      checks++;
      if (tick !== 1'b1 || Q !== 4'd2 || wrap !== 1'b0) begin errors++; $display("FAIL hold_tick%0d: got q %0d tick %b wrap %b expected 2 1 0", k, Q, tick, wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_odd_step();
    test_collision();
    test_freeze_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
